alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
- Arbitrates one shared combinational ALU (8-bit operand `num1`, 3-bit `op`, 32-bit `res`) between two requesters.
- Sequences each accepted request through a fixed IDLE→EXEC→RESP flow:
  - registers the operand and opcode and drives them to the ALU;
  - captures the ALU result;
  - returns the result through a valid/ready response port tagged with the requester id.
- Sits between the instruction/test front-ends and the ALU datapath. The ALU is instantiated outside this block.

Parameters:
- W_NUM, 8, operand width driven to ALU num1
- W_OP, 3, opcode width
- W_RES, 32, ALU result width
- OP_MAX, 3'b101, highest legal opcode; opcodes above it are rejected with an error response

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has a request
- req0_ready  out  1  request 0 accepted this cycle
- req0_num1  in  W_NUM  requester 0 operand
- req0_op  in  W_OP  requester 0 opcode
- req1_valid / req1_ready / req1_num1 / req1_op  same as requester 0, for requester 1
- alu_num1  out  W_NUM  registered operand to ALU
- alu_op  out  W_OP  registered opcode to ALU
- alu_res  in  W_RES  ALU result (combinational from alu_num1/alu_op)
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_id  out  1  requester that owns the response
- resp_res  out  W_RES  captured result
- resp_err  out  1  illegal opcode (op > OP_MAX)
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, rst=1 at a rising edge of clk):
  - state=IDLE, rr_ptr=0 (requester 0 has priority first);
  - alu_num1=0, alu_op=0;
  - resp_valid=0, resp_id=0, resp_res=0, resp_err=0, busy=0.
  - Reset mid-operation discards the in-flight request and any pending response; no response is emitted for it.
- State machine (states IDLE, EXEC, RESP):
  - IDLE:
    - reqN_ready is combinational and high only in IDLE, for the granted requester.
    - Grant: if exactly one valid, grant it. If both valid, grant req[rr_ptr].
    - On a grant: latch num1/op into alu_num1/alu_op, latch id, go to EXEC.
    - No valid requests: stay in IDLE, outputs hold.
  - EXEC (exactly 1 cycle):
    - alu_num1/alu_op are stable for the whole cycle.
    - At the clock edge, resp_res<=alu_res if op<=OP_MAX; otherwise resp_res<=0 and resp_err<=1.
    - resp_id<=latched id; resp_valid<=1; go to RESP.
  - RESP:
    - resp_valid, resp_id, resp_res and resp_err hold stable until resp_ready=1.
    - On handshake: resp_valid<=0, resp_err<=0, rr_ptr<=~resp_id, go to IDLE.
    - A new request cannot be accepted in the same cycle as the handshake.
- Latency:
  - Request accept cycle T → resp_valid high at T+2.
  - Minimum request spacing is 3 cycles with resp_ready held high.
- alu_num1/alu_op hold their last value in RESP and IDLE; they are not cleared.
- Requesters must hold num1/op stable while valid and not ready. The controller samples them only in the accept cycle.
- Round-robin fairness: under continuous contention, grants alternate 0,1,0,1…
- A request that arrives while busy waits; valid is never dropped by the controller.
- No width conversion: alu_res is passed through unmodified in W_RES bits.

Decomposition:
- Package alu_pkg:
  - W_NUM, W_OP, W_RES;
  - opcode constants OP_0..OP_5 (3'b000..3'b101) and OP_MAX;
  - state enum {IDLE, EXEC, RESP}.
- Sub-module rr_arb2 (2-way round-robin grant from valid[1:0] and rr_ptr). Everything else lives in alu_share_ctrl.

Test Plan:
- Bench ALU stub for all scenarios: alu_res = {21'd0, alu_op, alu_num1}.
- Single request, no contention: req0 num1=8'd2 op=3'b000, resp_ready=1 → req0_ready high in the accept cycle; 2 cycles later resp_valid=1, resp_id=0, resp_res=32'h0000_0002, resp_err=0.
- Simultaneous requests after reset: req0 (8'd255, 3'b001) and req1 (8'd254, 3'b010) both valid:
  - requester 0 is served first: resp_res=32'h0000_01FF, id=0;
  - then requester 1: resp_res=32'h0000_02FE, id=1.
- Continuous contention over 4 requests per side → resp_id sequence 0,1,0,1,0,1,0,1; no starvation.
- Backpressure: req1 (8'd170, 3'b011), resp_ready=0 for 5 cycles → resp_valid, resp_id=1 and resp_res=32'h0000_03AA stay stable; busy=1; req0_ready=0 throughout; completes on the first resp_ready=1.
- Illegal opcode: req0 (8'd240, 3'b110) → resp_err=1, resp_res=0. A following legal request (8'd129, 3'b101) → resp_err=0, resp_res=32'h0000_0581.
- Reset in EXEC and in RESP → next cycle state IDLE, resp_valid=0, alu_num1=0, alu_op=0, busy=0; a new request after reset behaves as in the first scenario.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths, opcodes and FSM states for the shared-ALU controller.
package alu_pkg;

    localparam int W_NUM = 8;
    localparam int W_OP  = 3;
    localparam int W_RES = 32;

    localparam logic [W_OP-1:0] OP_0   = 3'b000;
    localparam logic [W_OP-1:0] OP_1   = 3'b001;
    localparam logic [W_OP-1:0] OP_2   = 3'b010;
    localparam logic [W_OP-1:0] OP_3   = 3'b011;
    localparam logic [W_OP-1:0] OP_4   = 3'b100;
    localparam logic [W_OP-1:0] OP_5   = 3'b101;
    localparam logic [W_OP-1:0] OP_MAX = OP_5;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    function automatic logic op_legal(input logic [W_OP-1:0] op);
        return op <= OP_MAX;
    endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request, ALU and response signals of the shared-ALU controller.
interface alu_share_ctrl_if;
    import alu_pkg::*;

    logic             req0_valid;
    logic             req0_ready;
    logic [W_NUM-1:0] req0_num1;
    logic [W_OP-1:0]  req0_op;
    logic             req1_valid;
    logic             req1_ready;
    logic [W_NUM-1:0] req1_num1;
    logic [W_OP-1:0]  req1_op;
    logic [W_NUM-1:0] alu_num1;
    logic [W_OP-1:0]  alu_op;
    logic [W_RES-1:0] alu_res;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [W_RES-1:0] resp_res;
    logic             resp_err;
    logic             busy;

    modport slave (
        input  req0_valid, req0_num1, req0_op,
        input  req1_valid, req1_num1, req1_op,
        input  alu_res, resp_ready,
        output req0_ready, req1_ready,
        output alu_num1, alu_op,
        output resp_valid, resp_id, resp_res, resp_err,
        output busy
    );

    modport master (
        output req0_valid, req0_num1, req0_op,
        output req1_valid, req1_num1, req1_op,
        output alu_res, resp_ready,
        input  req0_ready, req1_ready,
        input  alu_num1, alu_op,
        input  resp_valid, resp_id, resp_res, resp_err,
        input  busy
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; i_ptr picks the winner only on contention.
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_ptr,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = i_valid;
        if (&i_valid) begin
            o_grant = i_ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters, one op at a time.
module alu_share_ctrl
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    alu_share_ctrl_if.slave  bus
);

    state_t           r_state;
    state_t           w_next;
    logic             r_rr_ptr;
    logic             r_id;
    logic [W_NUM-1:0] r_alu_num1;
    logic [W_OP-1:0]  r_alu_op;
    logic             r_resp_valid;
    logic             r_resp_id;
    logic [W_RES-1:0] r_resp_res;
    logic             r_resp_err;

    logic [1:0]       w_req_valid;
    logic [1:0]       w_arb_grant;
    logic [1:0]       w_grant;
    logic             w_hs;

    assign w_req_valid = {bus.req1_valid, bus.req0_valid};
    assign w_hs        = r_resp_valid & bus.resp_ready;

    rr_arb2 u_arb (
        .i_valid (w_req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_arb_grant)
    );

    always_comb begin
        w_next  = r_state;
        w_grant = 2'b00;
        unique case (r_state)
            IDLE: begin
                w_grant = w_arb_grant;
                if (|w_arb_grant) begin
                    w_next = EXEC;
                end
            end
            EXEC: w_next = RESP;
            RESP: begin
                if (w_hs) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr     <= 1'b0;
            r_id         <= 1'b0;
            r_alu_num1   <= '0;
            r_alu_op     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_res   <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            if (|w_grant) begin
                r_alu_num1 <= w_grant[1] ? bus.req1_num1 : bus.req0_num1;
                r_alu_op   <= w_grant[1] ? bus.req1_op : bus.req0_op;
                r_id       <= w_grant[1];
            end
            // Illegal opcodes never expose the ALU output.
            if (r_state == EXEC) begin
                r_resp_res   <= op_legal(r_alu_op) ? bus.alu_res : '0;
                r_resp_err   <= ~op_legal(r_alu_op);
                r_resp_id    <= r_id;
                r_resp_valid <= 1'b1;
            end
            if ((r_state == RESP) && w_hs) begin
                r_resp_valid <= 1'b0;
                r_resp_err   <= 1'b0;
                r_rr_ptr     <= ~r_resp_id;
            end
        end
    end

    assign bus.req0_ready = w_grant[0];
    assign bus.req1_ready = w_grant[1];
    assign bus.alu_num1   = r_alu_num1;
    assign bus.alu_op     = r_alu_op;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_id    = r_resp_id;
    assign bus.resp_res   = r_resp_res;
    assign bus.resp_err   = r_resp_err;
    assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Random and directed bench for alu_share_ctrl against a transaction model.
module tb_alu_share_ctrl;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_share_ctrl_if bus ();

    alu_share_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.alu_res = {21'd0, bus.alu_op, bus.alu_num1};

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: what the consumer should see, from the spec rules only.
    int          m_phase;
    bit          m_ptr;
    bit          m_id;
    logic [7:0]  m_num;
    logic [2:0]  m_op;
    bit          m_rv;
    bit          m_rid;
    logic [31:0] m_rres;
    bit          m_rerr;
    bit          m_acc0;
    bit          m_acc1;
    bit          m_hs;
    int          cyc;
    int          acc_cyc;
    int          n_acc0;
    int          n_acc1;
    bit          grant_q[$];

    function automatic logic [31:0] ref_res(input logic [7:0] n,
                                            input logic [2:0] o);
        if (o > 3'd5) return 32'd0;
        return {21'd0, o, n};
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_ptr   = 1'b0;
        m_id    = 1'b0;
        m_num   = '0;
        m_op    = '0;
        m_rv    = 1'b0;
        m_rid   = 1'b0;
        m_rres  = '0;
        m_rerr  = 1'b0;
    endtask

    task automatic cycle();
        #1;
        m_acc0 = 1'b0;
        m_acc1 = 1'b0;
        if (m_phase == 0) begin
            if (bus.req0_valid && bus.req1_valid) begin
                m_acc0 = !m_ptr;
                m_acc1 = m_ptr;
            end else begin
                m_acc0 = bus.req0_valid;
                m_acc1 = bus.req1_valid;
            end
        end
        chk("req0_ready", 32'(bus.req0_ready), 32'(m_acc0));
        chk("req1_ready", 32'(bus.req1_ready), 32'(m_acc1));
        m_hs = (m_phase == 2) && bus.resp_ready;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else if (m_phase == 0) begin
            if (m_acc0 || m_acc1) begin
                m_id    = m_acc1;
                m_num   = m_acc1 ? bus.req1_num1 : bus.req0_num1;
                m_op    = m_acc1 ? bus.req1_op : bus.req0_op;
                m_phase = 1;
                acc_cyc = cyc;
                grant_q.push_back(m_acc1);
                if (m_acc0) n_acc0++;
                if (m_acc1) n_acc1++;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
            m_rv    = 1'b1;
            m_rid   = m_id;
            m_rerr  = (m_op > 3'd5);
            m_rres  = ref_res(m_num, m_op);
        end else if (m_hs) begin
            m_phase = 0;
            m_rv    = 1'b0;
            m_rerr  = 1'b0;
            m_ptr   = !m_rid;
        end
        cyc++;
        if (m_acc0) bus.req0_valid = 1'b0;
        if (m_acc1) bus.req1_valid = 1'b0;
        chk("resp_valid", 32'(bus.resp_valid), 32'(m_rv));
        chk("resp_err", 32'(bus.resp_err), 32'(m_rerr));
        chk("busy", 32'(bus.busy), 32'(m_phase != 0));
        chk("alu_num1", 32'(bus.alu_num1), 32'(m_num));
        chk("alu_op", 32'(bus.alu_op), 32'(m_op));
        if (m_rv || rst) begin
            chk("resp_id", 32'(bus.resp_id), 32'(m_rid));
            chk("resp_res", bus.resp_res, m_rres);
        end
    endtask

    task automatic wait_resp(input string tag, input bit id,
                             input logic [31:0] res, input bit err);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            seen = bus.resp_valid;
        end
        if (!seen) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_id"}, 32'(bus.resp_id), 32'(id));
            chk({tag, "_res"}, bus.resp_res, res);
            chk({tag, "_err"}, 32'(bus.resp_err), 32'(err));
            chk({tag, "_lat"}, 32'(cyc - acc_cyc), 32'd2);
        end
    endtask

    task automatic req0(input logic [7:0] n, input logic [2:0] o);
        bus.req0_valid = 1'b1;
        bus.req0_num1  = n;
        bus.req0_op    = o;
    endtask

    task automatic req1(input logic [7:0] n, input logic [2:0] o);
        bus.req1_valid = 1'b1;
        bus.req1_num1  = n;
        bus.req1_op    = o;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic drain();
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req0_num1  = '0;
        bus.req0_op    = '0;
        bus.req1_valid = 1'b0;
        bus.req1_num1  = '0;
        bus.req1_op    = '0;
        bus.resp_ready = 1'b1;
        cyc     = 0;
        acc_cyc = 0;
        n_acc0  = 0;
        n_acc1  = 0;
        model_reset();
        @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_res", bus.resp_res, 32'd0);

        req0(8'd2, 3'b000);
        wait_resp("single", 1'b0, 32'h0000_0002, 1'b0);
        cycle();

        do_reset();
        req0(8'd255, 3'b001);
        req1(8'd254, 3'b010);
        wait_resp("both_a", 1'b0, 32'h0000_01FF, 1'b0);
        wait_resp("both_b", 1'b1, 32'h0000_02FE, 1'b0);
        drain();

        grant_q.delete();
        n_acc0 = 0;
        n_acc1 = 0;
        req0(8'($urandom), 3'($urandom));
        req1(8'($urandom), 3'($urandom));
        for (int i = 0; i < 80 && (n_acc0 + n_acc1) < 8; i++) begin
            cycle();
            if (!bus.req0_valid && n_acc0 < 4)
                req0(8'($urandom), 3'($urandom));
            if (!bus.req1_valid && n_acc1 < 4)
                req1(8'($urandom), 3'($urandom));
        end
        chk("rr_count", 32'(grant_q.size()), 32'd8);
        for (int k = 0; k < grant_q.size(); k++)
            chk("rr_order", 32'(grant_q[k]), 32'(k % 2));
        drain();

        bus.resp_ready = 1'b0;
        req1(8'd170, 3'b011);
        wait_resp("bp", 1'b1, 32'h0000_03AA, 1'b0);
        req0(8'd7, 3'b001);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_valid", 32'(bus.resp_valid), 32'd1);
            chk("bp_id", 32'(bus.resp_id), 32'd1);
            chk("bp_res", bus.resp_res, 32'h0000_03AA);
            chk("bp_busy", 32'(bus.busy), 32'd1);
            chk("bp_r0rdy", 32'(bus.req0_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        cycle();
        chk("bp_done", 32'(bus.resp_valid), 32'd0);
        drain();

        req0(8'd240, 3'b110);
        wait_resp("illegal", 1'b0, 32'h0, 1'b1);
        req0(8'd129, 3'b101);
        wait_resp("legal", 1'b0, 32'h0000_0581, 1'b0);
        drain();

        req0(8'($urandom), 3'($urandom));
        cycle();
        do_reset();
        chk("rexec_busy", 32'(bus.busy), 32'd0);
        chk("rexec_valid", 32'(bus.resp_valid), 32'd0);
        chk("rexec_num1", 32'(bus.alu_num1), 32'd0);
        chk("rexec_op", 32'(bus.alu_op), 32'd0);

        req1(8'($urandom), 3'($urandom));
        cycle();
        cycle();
        bus.resp_ready = 1'b0;
        do_reset();
        bus.resp_ready = 1'b1;
        chk("rresp_busy", 32'(bus.busy), 32'd0);
        chk("rresp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rresp_num1", 32'(bus.alu_num1), 32'd0);
        chk("rresp_op", 32'(bus.alu_op), 32'd0);
        req0(8'd2, 3'b000);
        wait_resp("after_rst", 1'b0, 32'h0000_0002, 1'b0);
        drain();

        for (int i = 0; i < 400; i++) begin
            if (!bus.req0_valid && $urandom_range(0, 2) == 0)
                req0(8'($urandom), 3'($urandom));
            if (!bus.req1_valid && $urandom_range(0, 2) == 0)
                req1(8'($urandom), 3'($urandom));
            bus.resp_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
